sobel_calc_mod: RTL

SOBEL_CALC_MOD -- requirements
Module: sobel_calc_mod

---
 rtl/sobel_calc_mod.sv | 113 +++++++++++
 1 files changed

// File: rtl/sobel_calc_mod.sv
// 3x3 Sobel gradient-magnitude engine: three-stage pipeline with a per-frame window counter.
// Optional binarised output is selected by defining SOBEL_THRESHOLD_EN.
module sobel_calc_mod #(
  parameter int unsigned ROWS      = 400,
  parameter int unsigned COLS      = 400,
  parameter int unsigned THRESHOLD = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] d0_i,
  input  logic [7:0] d1_i,
  input  logic [7:0] d2_i,
  input  logic [7:0] d3_i,
  input  logic [7:0] d4_i,
  input  logic [7:0] d5_i,
  input  logic [7:0] d6_i,
  input  logic [7:0] d7_i,
  input  logic [7:0] d8_i,
  input  logic       done_i,
  output logic [7:0] edge_o,
  output logic       done_o,
  output logic       frame_done_o
);

  localparam int unsigned Windows = (ROWS - 2) * (COLS - 2);
  localparam int unsigned CntW    = (Windows > 1) ? $clog2(Windows) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Windows - 1);

  // Stage 1: signed gradients
  logic        [10:0] gx_pos, gx_neg, gy_pos, gy_neg;
  logic signed [10:0] gx_d, gy_d, gx_q, gy_q;
  logic               v1_q;

  // Stage 2: absolute values
  logic [10:0] ax_d, ay_d, ax_q, ay_q;
  logic        v2_q;

  // Stage 3: saturated (or binarised) magnitude
  logic [10:0] mag;
  logic [7:0]  sat;
  logic [7:0]  edge_d, edge_q;
  logic        v3_q;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    gx_pos = {3'b0, d2_i} + {2'b0, d5_i, 1'b0} + {3'b0, d8_i};
    gx_neg = {3'b0, d0_i} + {2'b0, d3_i, 1'b0} + {3'b0, d6_i};
    gy_pos = {3'b0, d6_i} + {2'b0, d7_i, 1'b0} + {3'b0, d8_i};
    gy_neg = {3'b0, d0_i} + {2'b0, d1_i, 1'b0} + {3'b0, d2_i};
    // Each side is at most 1020, so the 11-bit difference is exact in two's complement
    gx_d   = $signed(gx_pos - gx_neg);
    gy_d   = $signed(gy_pos - gy_neg);
  end

  always_comb begin
    ax_d = gx_q[10] ? (~gx_q + 11'd1) : gx_q;
    ay_d = gy_q[10] ? (~gy_q + 11'd1) : gy_q;
  end

  always_comb begin
    mag = ax_q + ay_q;
    sat = (mag > 11'd255) ? 8'hFF : mag[7:0];
`ifdef SOBEL_THRESHOLD_EN
    edge_d = (32'(sat) >= THRESHOLD) ? 8'hFF : 8'h00;
`else
    edge_d = sat;
`endif
  end

  always_comb begin
    cnt_d = cnt_q;
    if (v3_q) begin
      cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + CntW'(1);
    end
  end

  // Data registers only load with their valid flag so idle cycles keep the held window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gx_q   <= '0;
      gy_q   <= '0;
      v1_q   <= 1'b0;
      ax_q   <= '0;
      ay_q   <= '0;
      v2_q   <= 1'b0;
      edge_q <= '0;
      v3_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      v1_q  <= done_i;
      v2_q  <= v1_q;
      v3_q  <= v2_q;
      cnt_q <= cnt_d;
      if (done_i) begin
        gx_q <= gx_d;
        gy_q <= gy_d;
      end
      if (v1_q) begin
        ax_q <= ax_d;
        ay_q <= ay_d;
      end
      if (v2_q) begin
        edge_q <= edge_d;
      end
    end
  end

  assign edge_o       = edge_q;
  assign done_o       = v3_q;
  assign frame_done_o = v3_q && (cnt_q == LastCnt);

endmodule
